// File: rtl/regex_cmd_controller.sv
// Command responder between the AXI-Lite register file and the regex coprocessor.
// Define REGEX_ELAPSED_COUNTER_EN to build the elapsed-clock counter; otherwise READ_ELAPSED_CLOCK returns 0.
module regex_cmd_controller #(
    parameter int REG_WIDTH  = 40,
    parameter int ADDR_WIDTH = 9
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [REG_WIDTH-1:0]  cmd_in,
    input  logic [REG_WIDTH-1:0]  addr_in,
    input  logic [REG_WIDTH-1:0]  data_in,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    output logic [REG_WIDTH-1:0]  data_out,
    output logic [REG_WIDTH-1:0]  status_out,
    output logic                  cmd_dropped,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [REG_WIDTH-1:0]  mem_wdata,
    output logic                  mem_we,
    input  logic [REG_WIDTH-1:0]  mem_rdata,
    output logic                  cp_start,
    output logic                  cp_reset,
    input  logic                  cp_done,
    input  logic                  cp_accepted,
    input  logic                  cp_error
);

    localparam logic [REG_WIDTH-1:0] CMD_NOP          = REG_WIDTH'(32'd0);
    localparam logic [REG_WIDTH-1:0] CMD_WRITE        = REG_WIDTH'(32'd1);
    localparam logic [REG_WIDTH-1:0] CMD_READ         = REG_WIDTH'(32'd2);
    localparam logic [REG_WIDTH-1:0] CMD_START        = REG_WIDTH'(32'd3);
    localparam logic [REG_WIDTH-1:0] CMD_RESET        = REG_WIDTH'(32'd4);
    localparam logic [REG_WIDTH-1:0] CMD_READ_ELAPSED = REG_WIDTH'(32'd5);
    localparam logic [REG_WIDTH-1:0] CMD_RESTART      = REG_WIDTH'(32'd6);

    localparam logic [REG_WIDTH-1:0] STATUS_IDLE      = REG_WIDTH'(32'd0);
    localparam logic [REG_WIDTH-1:0] STATUS_RUNNING   = REG_WIDTH'(32'd1);
    localparam logic [REG_WIDTH-1:0] STATUS_ACCEPTED  = REG_WIDTH'(32'd2);
    localparam logic [REG_WIDTH-1:0] STATUS_REJECTED  = REG_WIDTH'(32'd3);
    localparam logic [REG_WIDTH-1:0] STATUS_ERROR     = REG_WIDTH'(32'd4);

    typedef enum logic [1:0] {
        ST_READY   = 2'd0,
        ST_RD_WAIT = 2'd1,
        ST_RUN     = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic                  cmd_ready_q, cmd_ready_d;
    logic [REG_WIDTH-1:0]  data_out_q, data_out_d;
    logic [REG_WIDTH-1:0]  status_q, status_d;
    logic                  cmd_dropped_q, cmd_dropped_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [REG_WIDTH-1:0]  mem_wdata_q, mem_wdata_d;
    logic                  mem_we_q, mem_we_d;
    logic                  cp_start_q, cp_start_d;
    logic                  cp_reset_q, cp_reset_d;

    logic                  accept_s;
    logic                  start_run_s;
    logic                  soft_reset_s;
    logic                  cnt_inc_s;
    logic [REG_WIDTH-1:0]  elapsed_s;
    logic                  addr_unused_s;

    assign accept_s      = cmd_valid && cmd_ready_q;
    assign addr_unused_s = ^addr_in[REG_WIDTH-1:ADDR_WIDTH];

    // Command decode, run supervision and next-state selection
    always_comb begin
        state_d       = state_q;
        data_out_d    = data_out_q;
        status_d      = status_q;
        mem_addr_d    = mem_addr_q;
        mem_wdata_d   = mem_wdata_q;
        mem_we_d      = 1'b0;
        cmd_dropped_d = 1'b0;
        start_run_s   = 1'b0;
        soft_reset_s  = 1'b0;
        cnt_inc_s     = 1'b0;
        case (state_q)
            ST_READY: begin
                if (accept_s) begin
                    case (cmd_in)
                        CMD_NOP: begin
                            status_d = status_q;
                        end
                        CMD_WRITE: begin
                            mem_we_d    = 1'b1;
                            mem_addr_d  = addr_in[ADDR_WIDTH-1:0];
                            mem_wdata_d = data_in;
                        end
                        CMD_READ: begin
                            mem_addr_d = addr_in[ADDR_WIDTH-1:0];
                            state_d    = ST_RD_WAIT;
                        end
                        CMD_START:        start_run_s  = 1'b1;
                        CMD_RESET:        soft_reset_s = 1'b1;
                        CMD_READ_ELAPSED: data_out_d   = elapsed_s;
                        CMD_RESTART: begin
                            if ((status_q == STATUS_ACCEPTED) || (status_q == STATUS_REJECTED)) begin
                                start_run_s = 1'b1;
                            end else begin
                                status_d = STATUS_ERROR;
                            end
                        end
                        default: status_d = STATUS_ERROR;
                    endcase
                end else begin
                    state_d = ST_READY;
                end
            end
            ST_RD_WAIT: begin
                data_out_d = mem_rdata;
                state_d    = ST_READY;
            end
            ST_RUN: begin
                cnt_inc_s = 1'b1;
                if (accept_s) begin
                    case (cmd_in)
                        CMD_RESET:        soft_reset_s  = 1'b1;
                        CMD_READ_ELAPSED: data_out_d    = elapsed_s;
                        CMD_NOP:          cmd_dropped_d = 1'b0;
                        default:          cmd_dropped_d = 1'b1;
                    endcase
                end else begin
                    cmd_dropped_d = 1'b0;
                end
                // cp_error ends the run even without cp_done and outranks it
                if (cp_error) begin
                    status_d = STATUS_ERROR;
                    state_d  = ST_READY;
                end else if (cp_done) begin
                    status_d = cp_accepted ? STATUS_ACCEPTED : STATUS_REJECTED;
                    state_d  = ST_READY;
                end else begin
                    state_d = ST_RUN;
                end
            end
            default: state_d = ST_READY;
        endcase
        // A RESET command overrides any completion sampled on the same edge
        if (soft_reset_s) begin
            status_d   = STATUS_IDLE;
            data_out_d = {REG_WIDTH{1'b0}};
            state_d    = ST_READY;
        end else if (start_run_s) begin
            status_d = STATUS_RUNNING;
            state_d  = ST_RUN;
        end else begin
            cmd_ready_d = 1'b1;
        end
        cmd_ready_d = (state_d != ST_RD_WAIT);
        cp_start_d  = start_run_s;
        cp_reset_d  = soft_reset_s;
    end

`ifdef REGEX_ELAPSED_COUNTER_EN
    logic [REG_WIDTH-1:0] cnt_q, cnt_d;

    assign elapsed_s = cnt_q;

    // Elapsed counter: cleared on start/reset, saturating count while running
    always_comb begin
        cnt_d = cnt_q;
        if (soft_reset_s || start_run_s) begin
            cnt_d = {REG_WIDTH{1'b0}};
        end else if (cnt_inc_s && (cnt_q != {REG_WIDTH{1'b1}})) begin
            cnt_d = cnt_q + {{(REG_WIDTH-1){1'b0}}, 1'b1};
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Elapsed counter register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= {REG_WIDTH{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    logic cnt_unused_s;

    assign elapsed_s    = {REG_WIDTH{1'b0}};
    assign cnt_unused_s = cnt_inc_s;
`endif

    // State and output registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= ST_READY;
            cmd_ready_q   <= 1'b1;
            data_out_q    <= {REG_WIDTH{1'b0}};
            status_q      <= STATUS_IDLE;
            cmd_dropped_q <= 1'b0;
            mem_addr_q    <= {ADDR_WIDTH{1'b0}};
            mem_wdata_q   <= {REG_WIDTH{1'b0}};
            mem_we_q      <= 1'b0;
            cp_start_q    <= 1'b0;
            cp_reset_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            cmd_ready_q   <= cmd_ready_d;
            data_out_q    <= data_out_d;
            status_q      <= status_d;
            cmd_dropped_q <= cmd_dropped_d;
            mem_addr_q    <= mem_addr_d;
            mem_wdata_q   <= mem_wdata_d;
            mem_we_q      <= mem_we_d;
            cp_start_q    <= cp_start_d;
            cp_reset_q    <= cp_reset_d;
        end
    end

    assign cmd_ready   = cmd_ready_q;
    assign data_out    = data_out_q;
    assign status_out  = status_q;
    assign cmd_dropped = cmd_dropped_q;
    assign mem_addr    = mem_addr_q;
    assign mem_wdata   = mem_wdata_q;
    assign mem_we      = mem_we_q;
    assign cp_start    = cp_start_q;
    assign cp_reset    = cp_reset_q;

endmodule

// File: tb/tb_regex_cmd_controller.sv
// Directed-plus-random bench for regex_cmd_controller with a behavioural memory/status model.
module tb_regex_cmd_controller;

    localparam int RW = 40;
    localparam int AW = 9;

    localparam logic [RW-1:0] C_NOP     = 40'd0;
    localparam logic [RW-1:0] C_WRITE   = 40'd1;
    localparam logic [RW-1:0] C_READ    = 40'd2;
    localparam logic [RW-1:0] C_START   = 40'd3;
    localparam logic [RW-1:0] C_RESET   = 40'd4;
    localparam logic [RW-1:0] C_ELAPSED = 40'd5;
    localparam logic [RW-1:0] C_RESTART = 40'd6;

    localparam logic [RW-1:0] S_IDLE    = 40'd0;
    localparam logic [RW-1:0] S_RUNNING = 40'd1;
    localparam logic [RW-1:0] S_ACC     = 40'd2;
    localparam logic [RW-1:0] S_REJ     = 40'd3;
    localparam logic [RW-1:0] S_ERROR   = 40'd4;

    logic          clk;
    logic          reset;
    logic [RW-1:0] cmd_in, addr_in, data_in;
    logic          cmd_valid, cmd_ready;
    logic [RW-1:0] data_out, status_out;
    logic          cmd_dropped;
    logic [AW-1:0] mem_addr;
    logic [RW-1:0] mem_wdata, mem_rdata;
    logic          mem_we, cp_start, cp_reset;
    logic          cp_done, cp_accepted, cp_error;

    regex_cmd_controller #(.REG_WIDTH(RW), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .reset(reset), .cmd_in(cmd_in), .addr_in(addr_in), .data_in(data_in),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .data_out(data_out),
        .status_out(status_out), .cmd_dropped(cmd_dropped), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata),
        .cp_start(cp_start), .cp_reset(cp_reset), .cp_done(cp_done),
        .cp_accepted(cp_accepted), .cp_error(cp_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Coprocessor memory: write on mem_we, read data follows the registered address
    logic [RW-1:0] mem_array [0:(1<<AW)-1];
    always @(posedge clk) if (mem_we) mem_array[mem_addr] <= mem_wdata;
    assign mem_rdata = mem_array[mem_addr];

    int n_start, n_reset, n_we, n_drop;
    always @(posedge clk) begin
        if (cp_start)    n_start++;
        if (cp_reset)    n_reset++;
        if (mem_we)      n_we++;
        if (cmd_dropped) n_drop++;
    end

    int            n_vec, n_err;
    int            run_len;
    logic [RW-1:0] exp_status, exp_data;
    logic [RW-1:0] ref_mem [int];
    int            wa [5];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic tick_run();
        tick();
        run_len++;
    endtask

    task automatic issue(input logic [RW-1:0] cmd, input logic [RW-1:0] a, input logic [RW-1:0] d);
        cmd_in    = cmd;
        addr_in   = a;
        data_in   = d;
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
    endtask

    function automatic logic [RW-1:0] wide_addr(input int a);
        logic [RW-1:0] r;
        r = {8'($urandom), 32'($urandom)};
        r[AW-1:0] = a[AW-1:0];
        return r;
    endfunction

    function automatic logic [RW-1:0] elapsed_model(input int edges);
`ifdef REGEX_ELAPSED_COUNTER_EN
        return RW'(edges);
`else
        return RW'(edges * 0);
`endif
    endfunction

    task automatic read_mem(input int a);
        issue(C_READ, wide_addr(a), 40'd0);
        chk("rd_addr", 64'(mem_addr), 64'(a));
        chk("rd_ready_low", 64'(cmd_ready), 64'd0);
        chk("rd_data_hold", 64'(data_out), 64'(exp_data));
        tick();
        exp_data = ref_mem[a];
        chk("rd_data", 64'(data_out), 64'(exp_data));
        chk("rd_ready_high", 64'(cmd_ready), 64'd1);
    endtask

    task automatic read_elapsed(input string tag, input int edges);
        issue(C_ELAPSED, 40'd0, 40'd0);
        exp_data = elapsed_model(edges);
        chk(tag, 64'(data_out), 64'(exp_data));
    endtask

    task automatic start_run(input logic [RW-1:0] cmd);
        int s0;
        s0 = n_start;
        issue(cmd, 40'd0, 40'd0);
        run_len    = 0;
        exp_status = S_RUNNING;
        chk("start_pulse", 64'(cp_start), 64'd1);
        chk("start_status", 64'(status_out), 64'(exp_status));
        tick_run();
        chk("start_pulse_end", 64'(cp_start), 64'd0);
        chk("start_count", 64'(n_start), 64'(s0 + 1));
        chk("run_status", 64'(status_out), 64'(exp_status));
    endtask

    task automatic finish_run(input int n, input logic done, input logic acc, input logic err);
        while (run_len < n - 1) tick_run();
        cp_done = done; cp_accepted = acc; cp_error = err;
        tick_run();
        cp_done = 1'b0; cp_accepted = 1'b0; cp_error = 1'b0;
        exp_status = err ? S_ERROR : (acc ? S_ACC : S_REJ);
        chk("end_status", 64'(status_out), 64'(exp_status));
        chk("end_ready", 64'(cmd_ready), 64'd1);
    endtask

    initial begin
        int a, n, s0, r0, w0, d0;
        logic [RW-1:0] d;
        reset = 1'b1; cmd_valid = 1'b0; cmd_in = '0; addr_in = '0; data_in = '0;
        cp_done = 1'b0; cp_accepted = 1'b0; cp_error = 1'b0;
        n_vec = 0; n_err = 0; run_len = 0;
        repeat (3) tick();
        chk("rst_ready", 64'(cmd_ready), 64'd1);
        chk("rst_status", 64'(status_out), 64'(S_IDLE));
        chk("rst_data", 64'(data_out), 64'd0);
        chk("rst_pulses", 64'({cmd_dropped, mem_we, cp_start, cp_reset}), 64'd0);
        chk("rst_mem_addr", 64'(mem_addr), 64'd0);
        chk("rst_mem_wdata", 64'(mem_wdata), 64'd0);
        reset = 1'b0;
        tick();
        exp_status = S_IDLE;
        exp_data   = '0;

        // Writes: the fixed test-plan pair first, then random ones
        w0 = n_we;
        for (int i = 0; i < 5; i++) begin
            a = (i == 0) ? 5 : int'($urandom_range(6, (1 << AW) - 1));
            d = (i == 0) ? 40'hAB_CDEF_0123 : {8'($urandom), 32'($urandom)};
            wa[i] = a;
            issue(C_WRITE, wide_addr(a), d);
            ref_mem[a] = d;
            chk("wr_we", 64'(mem_we), 64'd1);
            chk("wr_addr", 64'(mem_addr), 64'(a));
            chk("wr_data", 64'(mem_wdata), 64'(d));
            chk("wr_status", 64'(status_out), 64'(exp_status));
            tick();
            chk("wr_we_end", 64'(mem_we), 64'd0);
        end
        chk("wr_count", 64'(n_we), 64'(w0 + 5));
        for (int i = 4; i >= 0; i--) read_mem(wa[i]);

        // Accepted run of exactly 10 edges
        start_run(C_START);
        finish_run(10, 1'b1, 1'b1, 1'b0);
        read_elapsed("elapsed_10", 10);

        // RESET command, then illegal RESTART from IDLE
        read_mem(5);
        r0 = n_reset;
        issue(C_RESET, 40'd0, 40'd0);
        exp_status = S_IDLE; exp_data = '0;
        chk("rst_cmd_pulse", 64'(cp_reset), 64'd1);
        chk("rst_cmd_status", 64'(status_out), 64'(exp_status));
        chk("rst_cmd_data", 64'(data_out), 64'(exp_data));
        tick();
        chk("rst_cmd_count", 64'(n_reset), 64'(r0 + 1));
        s0 = n_start;
        issue(C_RESTART, 40'd0, 40'd0);
        exp_status = S_ERROR;
        chk("restart_idle_status", 64'(status_out), 64'(exp_status));
        chk("restart_idle_nostart", 64'(cp_start), 64'd0);
        issue(C_NOP, 40'd0, 40'd0);
        chk("error_sticky_nop", 64'(status_out), 64'(exp_status));
        chk("restart_idle_count", 64'(n_start), 64'(s0));
        read_elapsed("elapsed_after_reset", 0);

        // Rejected run of random length, then legal RESTART
        n = int'($urandom_range(3, 40));
        start_run(C_START);
        finish_run(n, 1'b1, 1'b0, 1'b0);
        read_elapsed("elapsed_rand", n);
        start_run(C_RESTART);

        // Commands refused while running
        w0 = n_we; d0 = n_drop;
        for (int i = 0; i < 3; i++) begin
            issue((i == 0) ? C_WRITE : (i == 1) ? C_READ : 40'h7, wide_addr(7), 40'h55);
            run_len++;
            chk("drop_pulse", 64'(cmd_dropped), 64'd1);
            chk("drop_no_we", 64'(mem_we), 64'd0);
            chk("drop_status", 64'(status_out), 64'(exp_status));
            chk("drop_ready", 64'(cmd_ready), 64'd1);
        end
        r0 = run_len;
        issue(C_ELAPSED, 40'd0, 40'd0);
        run_len++;
        chk("live_elapsed", 64'(data_out), 64'(elapsed_model(r0)));
        chk("drop_count", 64'(n_drop), 64'(d0 + 3));
        chk("drop_we_count", 64'(n_we), 64'(w0));
        finish_run(run_len + 2, 1'b1, 1'b1, 1'b1);

        // ERROR is sticky through a write; cp_error alone ends a START run
        issue(C_WRITE, wide_addr(5), 40'h12_3456_789A);
        ref_mem[5] = 40'h12_3456_789A;
        chk("error_sticky_write", 64'(status_out), 64'(exp_status));
        start_run(C_START);
        finish_run(4, 1'b0, 1'b0, 1'b1);
        read_elapsed("elapsed_err", 4);

        // RESET command on the same edge as cp_done
        read_mem(5);
        start_run(C_START);
        repeat (3) tick_run();
        r0 = n_reset;
        cp_done = 1'b1; cp_accepted = 1'b1;
        issue(C_RESET, 40'd0, 40'd0);
        cp_done = 1'b0; cp_accepted = 1'b0;
        exp_status = S_IDLE; exp_data = '0;
        chk("rst_vs_done_status", 64'(status_out), 64'(exp_status));
        chk("rst_vs_done_data", 64'(data_out), 64'(exp_data));
        chk("rst_vs_done_pulse", 64'(cp_reset), 64'd1);
        read_elapsed("rst_vs_done_elapsed", 0);

        // Asynchronous reset mid-run: immediate abort, no cp_reset
        read_mem(5);
        start_run(C_START);
        repeat (4) tick_run();
        r0 = n_reset;
        #2 reset = 1'b1;
        #1;
        exp_status = S_IDLE; exp_data = '0;
        chk("async_run_status", 64'(status_out), 64'(exp_status));
        chk("async_run_data", 64'(data_out), 64'(exp_data));
        chk("async_run_pulses", 64'({cp_start, cp_reset, mem_we}), 64'd0);
        tick();
        reset = 1'b0;
        tick();
        chk("async_no_cp_reset", 64'(n_reset), 64'(r0));
        read_elapsed("async_elapsed", 0);

        // cp_done / cp_error outside RUN are ignored
        cp_done = 1'b1; cp_error = 1'b1; cp_accepted = 1'b1;
        tick();
        cp_done = 1'b0; cp_error = 1'b0; cp_accepted = 1'b0;
        tick();
        chk("done_outside_run", 64'(status_out), 64'(exp_status));

        // Asynchronous reset while a read is pending
        issue(C_READ, wide_addr(5), 40'd0);
        chk("async_rd_ready_low", 64'(cmd_ready), 64'd0);
        #2 reset = 1'b1;
        #1;
        chk("async_rd_ready", 64'(cmd_ready), 64'd1);
        chk("async_rd_addr", 64'(mem_addr), 64'd0);
        tick();
        reset = 1'b0;
        tick();
        chk("async_rd_data", 64'(data_out), 64'd0);

        // Unknown command code in READY
        issue(40'($urandom_range(8, 65535)), 40'd0, 40'd0);
        exp_status = S_ERROR;
        chk("unknown_cmd", 64'(status_out), 64'(exp_status));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
